// File: rtl/perceptron_accum_ctrl.sv
// Perceptron pre-activation accumulator: bias plus NUM_TERMS streamed terms,
// summed in sign-magnitude with saturation, handed to the activation stage
// over a valid/ready handshake. The sign-magnitude adder lives in this file.

module fixed_point_adder #(
  parameter int SIGN = 1,
  parameter int Q_M  = 16,
  parameter int Q_N  = 15
) (
  input  logic [SIGN+Q_M+Q_N-1:0] i_a,
  input  logic [SIGN+Q_M+Q_N-1:0] i_b,
  output logic [SIGN+Q_M+Q_N-1:0] o_sum
);
  localparam int MW = Q_M + Q_N;

  logic          w_sa;
  logic          w_sb;
  logic [MW-1:0] w_ma;
  logic [MW-1:0] w_mb;
  logic [MW-1:0] w_mag;
  logic          w_sign;

  assign w_sa = i_a[MW];
  assign w_sb = i_b[MW];
  assign w_ma = i_a[MW-1:0];
  assign w_mb = i_b[MW-1:0];

  // Sign-magnitude add: like signs add magnitudes (carry dropped), unlike
  // signs subtract the smaller magnitude from the larger. Zero is always +0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_mag  = '0;
    w_sign = 1'b0;
    if (w_sa == w_sb) begin
      w_mag  = w_ma + w_mb;
      w_sign = w_sa;
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end
    if (w_mag == '0) w_sign = 1'b0;
  end

  assign o_sum = {w_sign, w_mag};
endmodule

module perceptron_accum_ctrl #(
  parameter int SIGN      = 1,
  parameter int Q_M       = 16,
  parameter int Q_N       = 15,
  parameter int NUM_TERMS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SIGN+Q_M+Q_N-1:0] bias_in,
  input  logic                    term_valid,
  input  logic [SIGN+Q_M+Q_N-1:0] term_data,
  output logic                    term_ready,
  output logic                    sum_valid,
  output logic [SIGN+Q_M+Q_N-1:0] sum_data,
  input  logic                    sum_ready,
  output logic                    busy,
  output logic                    overflow
);
  localparam int W  = SIGN + Q_M + Q_N;
  localparam int MW = Q_M + Q_N;
  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [W-1:0]  w_add_sum;
  logic          w_carry_lost;
  logic [W-1:0]  w_sat_sum;
  logic          w_term_hs;
  logic          w_start_hs;

  fixed_point_adder #(.SIGN(SIGN), .Q_M(Q_M), .Q_N(Q_N)) u_adder (
    .i_a   (r_acc),
    .i_b   (term_data),
    .o_sum (w_add_sum)
  );

  // With like signs the adder drops the carry; a magnitude that shrank means
  // the true sum exceeded full scale, so clamp to the largest magnitude.
  assign w_carry_lost = (r_acc[W-1] == term_data[W-1]) &&
                        (w_add_sum[MW-1:0] < r_acc[MW-1:0]);
  assign w_sat_sum    = w_carry_lost ? {r_acc[W-1], {MW{1'b1}}} : w_add_sum;

  assign w_start_hs = (r_state == S_IDLE) && start;
  assign w_term_hs  = (r_state == S_ACCUM) && term_valid;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    w_next     = r_state;
    term_ready = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        term_ready = 1'b1;
        busy       = 1'b1;
        if (term_valid && (r_count == LAST)) w_next = S_DONE;
      end
      S_DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (sum_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Accumulator, term counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_hs) begin
      // A -0 bias is folded to +0 so the accumulator never holds -0.
      r_acc      <= (bias_in[MW-1:0] == '0) ? '0 : bias_in;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_term_hs) begin
      r_acc   <= w_sat_sum;
      r_count <= r_count + CW'(1);
      if (w_carry_lost) r_overflow <= 1'b1;
    end
  end

  assign sum_data = r_acc;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_perceptron_accum_ctrl.sv
// Directed bench for perceptron_accum_ctrl: one instance with NUM_TERMS=4 for
// most scenarios and one with NUM_TERMS=1 for the single-term corner.
`timescale 1ns/1ps
module tb_perceptron_accum_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, term_valid, sum_ready;
  logic [31:0] bias_in, term_data;
  logic        term_ready, sum_valid, busy, overflow;
  logic [31:0] sum_data;

  logic        start1, term_valid1, sum_ready1;
  logic [31:0] bias_in1, term_data1;
  logic        term_ready1, sum_valid1, busy1, overflow1;
  logic [31:0] sum_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perceptron_accum_ctrl #(.NUM_TERMS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
    .term_valid(term_valid), .term_data(term_data), .term_ready(term_ready),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_ready(sum_ready),
    .busy(busy), .overflow(overflow)
  );

  perceptron_accum_ctrl #(.NUM_TERMS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bias_in(bias_in1),
    .term_valid(term_valid1), .term_data(term_data1), .term_ready(term_ready1),
    .sum_valid(sum_valid1), .sum_data(sum_data1), .sum_ready(sum_ready1),
    .busy(busy1), .overflow(overflow1)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sum(input logic [31:0] b);
    start   = 1'b1;
    bias_in = b;
    tick();
    start   = 1'b0;
  endtask

  task automatic release_sum;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (sum_valid !== 1'b0)  begin errors++; $display("FAIL reset_sum_valid got %b want 0", sum_valid); end
    checks++; if (term_ready !== 1'b0) begin errors++; $display("FAIL reset_term_ready got %b want 0", term_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (sum_data !== 32'h0)  begin errors++; $display("FAIL reset_sum_data got %h want 0", sum_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_sum;
    logic [31:0] t [4];
    t = '{32'h0001_0000, 32'h8000_4000, 32'h0000_2000, 32'h8001_8000};
    begin_sum(32'h0000_8000);
    checks++; if (term_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_accum_entry got ready=%b busy=%b want 1 1", term_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      term_valid = 1'b1;
      term_data  = t[i];
      tick();
      if (i < 3) begin
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid term %0d got %b want 0", i, sum_valid); end
      end
    end
    term_valid = 1'b0;
    checks++; if (sum_valid !== 1'b1)        begin errors++; $display("FAIL basic_sum_valid got %b want 1", sum_valid); end
    checks++; if (sum_data !== 32'h8000_2000) begin errors++; $display("FAIL basic_sum_data got %h want 80002000", sum_data); end
    checks++; if (overflow !== 1'b0)         begin errors++; $display("FAIL basic_overflow got %b want 0", overflow); end
    release_sum();
    checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_release got valid=%b busy=%b want 0 0", sum_valid, busy); end
  endtask

  task automatic test_saturation;
    logic [31:0] t [4];
    logic [31:0] e [4];
    t = '{32'h0002_0000, 32'h8000_8000, 32'h0000_0000, 32'h0000_0000};
    e = '{32'h7FFF_FFFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF};
    begin_sum(32'h7FFF_0000);
    for (int i = 0; i < 4; i++) begin
      term_valid = 1'b1;
      term_data  = t[i];
      tick();
      checks++; if (sum_data !== e[i]) begin errors++; $display("FAIL sat_acc term %0d got %h want %h", i, sum_data, e[i]); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow term %0d got %b want 1", i, overflow); end
    end
    term_valid = 1'b0;
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL sat_sum_valid got %b want 1", sum_valid); end
    release_sum();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_sticky_idle got %b want 1", overflow); end
    // Negative saturation on the next sum; start must clear the flag first.
    begin_sum(32'hFFFF_0000);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_start_clears got %b want 0", overflow); end
    term_valid = 1'b1;
    term_data  = 32'h8002_0000;
    tick();
    checks++; if (sum_data !== 32'hFFFF_FFFF || overflow !== 1'b1) begin errors++; $display("FAIL sat_negative got %h ovf=%b want ffffffff 1", sum_data, overflow); end
    term_data = 32'h0000_0000;
    tick(); tick(); tick();
    term_valid = 1'b0;
    checks++; if (sum_data !== 32'hFFFF_FFFF || sum_valid !== 1'b1) begin errors++; $display("FAIL sat_negative_final got %h valid=%b want ffffffff 1", sum_data, sum_valid); end
    release_sum();
  endtask

  task automatic test_zero_norm;
    begin_sum(32'h8000_0000);
    checks++; if (sum_data !== 32'h0) begin errors++; $display("FAIL zero_neg_bias got %h want 0", sum_data); end
    term_valid = 1'b1;
    term_data  = 32'h8000_0000;
    tick();
    checks++; if (sum_data !== 32'h0) begin errors++; $display("FAIL zero_neg_term got %h want 0", sum_data); end
    tick(); tick(); tick();
    term_valid = 1'b0;
    release_sum();
    begin_sum(32'h0000_C000);
    term_valid = 1'b1;
    term_data  = 32'h8000_C000;
    tick();
    checks++; if (sum_data !== 32'h0) begin errors++; $display("FAIL zero_cancel got %h want 0", sum_data); end
    term_data = 32'h0000_0000;
    tick(); tick(); tick();
    term_valid = 1'b0;
    checks++; if (sum_data !== 32'h0 || sum_valid !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL zero_final got %h valid=%b ovf=%b want 0 1 0", sum_data, sum_valid, overflow); end
    release_sum();
  endtask

  task automatic test_backpressure;
    logic [31:0] t [4];
    logic [31:0] e [4];
    logic [31:0] exp_acc;
    t = '{32'h0000_1000, 32'h0000_2000, 32'h8000_3000, 32'h0000_4000};
    e = '{32'h0001_1000, 32'h0001_3000, 32'h0001_0000, 32'h0001_4000};
    exp_acc = 32'h0001_0000;
    begin_sum(32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      term_valid = (i % 3 == 0);
      term_data  = term_valid ? t[i/3] : 32'h7FFF_FFFF;
      start      = (i == 1);
      bias_in    = 32'h0055_0000;
      tick();
      if (term_valid) exp_acc = e[i/3];
      checks++; if (sum_data !== exp_acc) begin errors++; $display("FAIL bp_acc cycle %0d got %h want %h", i, sum_data, exp_acc); end
      if (i < 9) begin
        checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid cycle %0d got %b want 0", i, sum_valid); end
      end
    end
    // Held in DONE: stray start and term traffic must not disturb the result.
    for (int i = 0; i < 3; i++) begin
      start      = (i == 1);
      term_valid = 1'b1;
      term_data  = 32'h0000_0100;
      tick();
      checks++; if (sum_valid !== 1'b1 || sum_data !== 32'h0001_4000) begin errors++; $display("FAIL bp_hold cycle %0d got valid=%b data=%h want 1 00014000", i, sum_valid, sum_data); end
    end
    start      = 1'b0;
    term_valid = 1'b0;
    release_sum();
    checks++; if (sum_valid !== 1'b0 || busy !== 1'b0 || term_ready !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b busy=%b ready=%b want 0 0 0", sum_valid, busy, term_ready); end
  endtask

  task automatic test_reset_mid;
    begin_sum(32'h7FFF_0000);
    term_valid = 1'b1;
    term_data  = 32'h0002_0000;
    tick();
    term_data  = 32'h0000_0000;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_ovf got %b want 1", overflow); end
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    term_valid = 1'b0;
    checks++; if (busy !== 1'b0 || term_ready !== 1'b0 || sum_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got busy=%b ready=%b valid=%b want 0 0 0", busy, term_ready, sum_valid); end
    checks++; if (overflow !== 1'b0 || sum_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got ovf=%b data=%h want 0 0", overflow, sum_data); end
    begin_sum(32'h0000_0000);
    term_valid = 1'b1;
    term_data  = 32'h0000_8000;
    tick(); tick(); tick(); tick();
    term_valid = 1'b0;
    checks++; if (sum_valid !== 1'b1 || sum_data !== 32'h0002_0000) begin errors++; $display("FAIL rst_mid_resum got valid=%b data=%h want 1 00020000", sum_valid, sum_data); end
    release_sum();
  endtask

  task automatic test_single_term;
    start1   = 1'b1;
    bias_in1 = 32'h0000_8000;
    tick();
    start1   = 1'b0;
    checks++; if (term_ready1 !== 1'b1 || sum_valid1 !== 1'b0) begin errors++; $display("FAIL one_accum got ready=%b valid=%b want 1 0", term_ready1, sum_valid1); end
    term_valid1 = 1'b1;
    term_data1  = 32'h0000_4000;
    tick();
    term_valid1 = 1'b0;
    checks++; if (sum_valid1 !== 1'b1 || sum_data1 !== 32'h0000_C000) begin errors++; $display("FAIL one_result got valid=%b data=%h want 1 0000c000", sum_valid1, sum_data1); end
    sum_ready1 = 1'b1;
    tick();
    sum_ready1 = 1'b0;
    checks++; if (sum_valid1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL one_release got valid=%b busy=%b want 0 0", sum_valid1, busy1); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; term_valid = 1'b0; sum_ready = 1'b0;
    bias_in = '0; term_data = '0;
    start1 = 1'b0; term_valid1 = 1'b0; sum_ready1 = 1'b0;
    bias_in1 = '0; term_data1 = '0;
    test_reset();
    test_basic_sum();
    test_saturation();
    test_zero_norm();
    test_backpressure();
    test_reset_mid();
    test_single_term();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/perceptron_accum_ctrl.md
# perceptron_accum_ctrl

Sequencing controller that drives the team's sign-magnitude `fixed_point_adder` (1 sign bit, Q16.15 magnitude) to compute one perceptron pre-activation: a bias plus `NUM_TERMS` weighted-input terms, accepted as a stream. It sits between the multiplier stage, which produces the terms, and the activation stage, which consumes the sum. It owns the accumulator register, term counter, saturation and handshakes, and instantiates one adder internally.

## Interface
- `SIGN`, 1: sign bits in the word; fixed at 1.
- `Q_M`, 16: integer magnitude bits.
- `Q_N`, 15: fractional magnitude bits.
- `NUM_TERMS`, 8: number of terms per sum; legal range is 1 or more.
- W = `SIGN+Q_M+Q_N` (32). Counter width is `$clog2(NUM_TERMS+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: **synchronous, active-high** reset.
- `start` in 1: begin a new sum. Sampled only in IDLE.
- `bias_in` in W: bias, sign-magnitude. Sampled on the cycle `start` is accepted.
- `term_valid` in 1: `term_data` is valid.
- `term_data` in W: term, sign-magnitude.
- `term_ready` out 1: controller accepts a term this cycle.
- `sum_valid` out 1: `sum_data` holds the final sum.
- `sum_data` out W: accumulated result, sign-magnitude.
- `sum_ready` in 1: consumer accepts the sum.
- `busy` out 1: high in any state other than IDLE.
- `overflow` out 1: sticky saturation flag for the current or last sum.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE:** `term_ready`=0 and `sum_valid`=0.
  - On `start`=1: acc <= `bias_in`, count <= 0, `overflow` <= 0, then go to ACCUM.
  - A bias of -0 (0x80000000) is stored as +0.
- **ACCUM:** `term_ready`=1.
  - On `term_valid && term_ready`: acc <= sat_add(acc, `term_data`) and count++.
  - When count equals NUM_TERMS-1 at that handshake, go to DONE.
  - With no valid term, hold acc and count.
- **DONE:** `sum_valid`=1 and `sum_data`=acc, held stable. On `sum_ready`=1, go to IDLE.
- `start` is ignored outside IDLE. `term_valid` is ignored outside ACCUM.
- **sat_add:** uses the adder output when the operand signs differ. When the operand signs are equal, overflow is detected as the adder magnitude being smaller than the acc magnitude (carry lost).
  - On overflow: result = {acc sign, all ones} (0x7FFFFFFF or 0xFFFFFFFF), and `overflow` <= 1.
  - `overflow` stays set until the next accepted `start`.
- A zero result is always +0, both from adder equal-magnitude cancellation and from saturation logic.
- `sum_data` reads acc in all states. It is only meaningful while `sum_valid`=1.

## Timing
- Reset (synchronous, checked at a `clk` edge):
  - State goes to IDLE.
  - acc, count, `term_ready`, `sum_valid`, `busy`, `overflow` and `sum_data` all go to 0.
- Reset overrides any in-flight operation in every state. The partial sum is discarded.
- `start` accepted at edge 0 → ACCUM from cycle 1; `term_ready` and `busy` are high in cycle 1.
- Throughput is one term per cycle. acc reflects a term one cycle after its handshake.
- Back-to-back terms: last handshake in cycle NUM_TERMS, `sum_valid` high in cycle NUM_TERMS+1. Minimum start-to-result is NUM_TERMS+1 cycles.
- Handshake in DONE: `sum_valid` falls the cycle after `sum_valid && sum_ready`. `start` can be accepted in the cycle after that (IDLE), never in the same cycle.
- `overflow` updates on the same edge as acc.

## Test plan
- **Basic sum:** NUM_TERMS=4, bias 0x00008000 (+1.0), terms 0x00010000, 0x80004000, 0x00002000, 0x80018000 sent back-to-back → `sum_valid` in cycle 5, `sum_data`=0x80002000 (−0.25), `overflow`=0.
- **Saturation:** bias 0x7FFF0000, terms 0x00020000, 0x80008000, 0x00000000, 0x00000000 → acc 0x7FFFFFFF after term 1, then 0x7FFF7FFF. Final 0x7FFF7FFF with `overflow`=1. Next `start` clears `overflow`.
- **Zero normalization:** bias 0x80000000 → acc 0x00000000. Bias 0x0000C000 with term 0x8000C000 → 0x00000000, never 0x80000000.
- **Backpressure:** `term_valid` toggles 1,0,0,1,…, and `sum_ready` is held low for 3 cycles in DONE.
  - acc changes only on handshakes.
  - `sum_data` stays stable while waiting.
  - `start` pulsed during ACCUM and DONE is ignored.
  - `sum_valid` drops the cycle after `sum_ready`.
- **Reset mid-operation:** assert `reset` after 2 of 4 terms → next cycle in IDLE with all outputs 0. A new `start` with bias 0 and four 0x00008000 terms → 0x00020000.
- **NUM_TERMS=1:** `start`, then one term → DONE in the cycle after the single handshake. Result is bias + term.
